// File: rtl/hwpe_axi_sink_ctrl.sv
// Sink-side sequencer for the AXI-Stream HWPE wrapper.
// Latches a job (per-stream bases, feature stride, feature count), drives the
// sink address generator enable/increment, advances all sink streams in
// lockstep against memory grants and rebases every stream on each feature
// boundary.
module hwpe_axi_sink_ctrl #(
  parameter int unsigned N_SINK_STREAMS = 4,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned FEAT_CNT_BITS  = 16
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 clear_i,
  input  logic                                 start_i,
  input  logic [N_SINK_STREAMS*ADDR_WIDTH-1:0] base_addr_i,
  input  logic [ADDR_WIDTH-1:0]                feat_stride_i,
  input  logic [FEAT_CNT_BITS-1:0]             n_feat_i,
  input  logic [N_SINK_STREAMS-1:0]            strm_valid_i,
  input  logic [N_SINK_STREAMS-1:0]            mem_gnt_i,
  output logic [N_SINK_STREAMS-1:0]            strm_ready_o,
  output logic [N_SINK_STREAMS-1:0]            ag_en_o,
  output logic [N_SINK_STREAMS-1:0]            ag_inc_o,
  output logic [N_SINK_STREAMS*ADDR_WIDTH-1:0] ag_base_addr_o,
  input  logic                                 ag_change_feat_i,
  output logic [FEAT_CNT_BITS-1:0]             feat_cnt_o,
  output logic                                 busy_o,
  output logic                                 evt_feat_o,
  output logic                                 done_o
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    FSWITCH,
    DONE
  } state_t;

  localparam logic [FEAT_CNT_BITS-1:0] FEAT_ONE = FEAT_CNT_BITS'(1);

  state_t                                   state_q, state_d;
  logic [N_SINK_STREAMS-1:0][ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH-1:0]                    stride_q;
  logic [FEAT_CNT_BITS-1:0]                 n_feat_q;
  logic [FEAT_CNT_BITS-1:0]                 feat_cnt_q;
  logic [FEAT_CNT_BITS-1:0]                 feat_cnt_nxt;
  logic                                     evt_q;

  logic fire;
  logic feat_step;
  logic last_feat;
  logic accept_start;

  // A beat moves only when every stream has data and every stream is granted;
  // a soft clear in the same cycle drops the beat.
  assign fire         = (state_q == RUN) & (&strm_valid_i) & (&mem_gnt_i) & ~clear_i;
  assign feat_step    = fire & ag_change_feat_i;
  assign feat_cnt_nxt = feat_cnt_q + FEAT_ONE;
  assign last_feat    = (feat_cnt_nxt == n_feat_q);
  assign accept_start = (state_q == IDLE) & start_i;

  assign ag_inc_o       = {N_SINK_STREAMS{fire}};
  assign strm_ready_o   = {N_SINK_STREAMS{fire}};
  assign ag_base_addr_o = base_q;
  assign feat_cnt_o     = feat_cnt_q;
  assign evt_feat_o     = evt_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    state_d = state_q;
    ag_en_o = '0;
    busy_o  = 1'b1;
    done_o  = 1'b0;
    unique case (state_q)
      IDLE: begin
        busy_o = 1'b0;
        if (start_i) state_d = LOAD;
      end
      LOAD: begin
        state_d = RUN;
      end
      RUN: begin
        ag_en_o = '1;
        if (feat_step) state_d = last_feat ? DONE : FSWITCH;
      end
      FSWITCH: begin
        state_d = RUN;
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (clear_i) state_d = IDLE;
  end

  // Job configuration, per-stream bases, feature counter and feature event.
  // Bases advance on the completing beat so the generator picks up the new
  // base during the FSWITCH (or DONE) cycle that follows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q     <= '0;
      stride_q   <= '0;
      n_feat_q   <= '0;
      feat_cnt_q <= '0;
      evt_q      <= 1'b0;
    end else if (clear_i) begin
      base_q     <= '0;
      stride_q   <= '0;
      n_feat_q   <= '0;
      feat_cnt_q <= '0;
      evt_q      <= 1'b0;
    end else begin
      evt_q <= feat_step;
      if (accept_start) begin
        base_q     <= base_addr_i;
        stride_q   <= feat_stride_i;
        n_feat_q   <= (n_feat_i == '0) ? FEAT_ONE : n_feat_i;
        feat_cnt_q <= '0;
      end
      if (feat_step) begin
        feat_cnt_q <= feat_cnt_nxt;
        for (int unsigned j = 0; j < N_SINK_STREAMS; j++) begin
          base_q[j] <= base_q[j] + stride_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_hwpe_axi_sink_ctrl.sv
// Directed bench for hwpe_axi_sink_ctrl (4 streams, 32-bit addresses).
module tb_hwpe_axi_sink_ctrl;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned FB = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            clear;
  logic            start;
  logic [N*AW-1:0] base_addr;
  logic [AW-1:0]   feat_stride;
  logic [FB-1:0]   n_feat;
  logic [N-1:0]    strm_valid;
  logic [N-1:0]    mem_gnt;
  logic [N-1:0]    strm_ready;
  logic [N-1:0]    ag_en;
  logic [N-1:0]    ag_inc;
  logic [N*AW-1:0] ag_base_addr;
  logic            ag_change_feat;
  logic [FB-1:0]   feat_cnt;
  logic            busy;
  logic            evt_feat;
  logic            done;

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  hwpe_axi_sink_ctrl #(
    .N_SINK_STREAMS(N),
    .ADDR_WIDTH    (AW),
    .FEAT_CNT_BITS (FB)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .clear_i         (clear),
    .start_i         (start),
    .base_addr_i     (base_addr),
    .feat_stride_i   (feat_stride),
    .n_feat_i        (n_feat),
    .strm_valid_i    (strm_valid),
    .mem_gnt_i       (mem_gnt),
    .strm_ready_o    (strm_ready),
    .ag_en_o         (ag_en),
    .ag_inc_o        (ag_inc),
    .ag_base_addr_o  (ag_base_addr),
    .ag_change_feat_i(ag_change_feat),
    .feat_cnt_o      (feat_cnt),
    .busy_o          (busy),
    .evt_feat_o      (evt_feat),
    .done_o          (done)
  );

  // Drives a start pulse in IDLE; returns at the negedge of the LOAD cycle.
  task automatic launch(input logic [N*AW-1:0] b, input logic [AW-1:0] s, input logic [FB-1:0] nf);
    @(negedge clk);
    start = 1'b1; base_addr = b; feat_stride = s; n_feat = nf;
    strm_valid = '0; mem_gnt = '0; ag_change_feat = 1'b0; clear = 1'b0;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    nchk++; if (busy !== 1'b0) begin nerr++; $display("FAIL reset_busy got=%b want=0", busy); end
    nchk++; if (done !== 1'b0) begin nerr++; $display("FAIL reset_done got=%b want=0", done); end
    nchk++; if (evt_feat !== 1'b0) begin nerr++; $display("FAIL reset_evt got=%b want=0", evt_feat); end
    nchk++; if (ag_en !== 4'h0) begin nerr++; $display("FAIL reset_en got=%h want=0", ag_en); end
    nchk++; if (ag_inc !== 4'h0) begin nerr++; $display("FAIL reset_inc got=%h want=0", ag_inc); end
    nchk++; if (strm_ready !== 4'h0) begin nerr++; $display("FAIL reset_ready got=%h want=0", strm_ready); end
    nchk++; if (ag_base_addr !== '0) begin nerr++; $display("FAIL reset_base got=%h want=0", ag_base_addr); end
    nchk++; if (feat_cnt !== 16'd0) begin nerr++; $display("FAIL reset_cnt got=%0d want=0", feat_cnt); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Three features of two beats each with everything always valid/granted.
  task automatic test_basic_job;
    logic [9:0]  ch_v, en_v, evt_v, done_v, busy_v;
    logic [31:0] exp_base [10];
    logic [15:0] exp_cnt  [10];
    int          n_evt, n_done;
    ch_v   = 10'b0010010010;
    en_v   = 10'b0011011011;
    evt_v  = 10'b0100100100;
    done_v = 10'b0100000000;
    busy_v = 10'b0111111111;
    exp_base = '{32'h100, 32'h100, 32'h140, 32'h140, 32'h140,
                 32'h180, 32'h180, 32'h180, 32'h1C0, 32'h1C0};
    exp_cnt  = '{16'd0, 16'd0, 16'd1, 16'd1, 16'd1, 16'd2, 16'd2, 16'd2, 16'd3, 16'd3};
    n_evt = 0; n_done = 0;
    launch({32'h400, 32'h300, 32'h200, 32'h100}, 32'h40, 16'd3);
    #1;
    nchk++; if (busy !== 1'b1) begin nerr++; $display("FAIL load_busy got=%b want=1", busy); end
    nchk++; if (ag_en !== 4'h0) begin nerr++; $display("FAIL load_en got=%h want=0", ag_en); end
    nchk++; if (ag_inc !== 4'h0) begin nerr++; $display("FAIL load_inc got=%h want=0", ag_inc); end
    nchk++; if (ag_base_addr[31:0] !== 32'h100) begin nerr++; $display("FAIL load_base0 got=%h want=100", ag_base_addr[31:0]); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      strm_valid = '1; mem_gnt = '1; ag_change_feat = ch_v[i];
      #1;
      if (evt_feat === 1'b1) n_evt++;
      if (done === 1'b1) n_done++;
      nchk++; if (ag_en !== {N{en_v[i]}}) begin nerr++; $display("FAIL job_en[%0d] got=%h want=%h", i, ag_en, {N{en_v[i]}}); end
      nchk++; if (ag_inc !== {N{en_v[i]}}) begin nerr++; $display("FAIL job_inc[%0d] got=%h want=%h", i, ag_inc, {N{en_v[i]}}); end
      nchk++; if (strm_ready !== {N{en_v[i]}}) begin nerr++; $display("FAIL job_ready[%0d] got=%h want=%h", i, strm_ready, {N{en_v[i]}}); end
      nchk++; if (evt_feat !== evt_v[i]) begin nerr++; $display("FAIL job_evt[%0d] got=%b want=%b", i, evt_feat, evt_v[i]); end
      nchk++; if (done !== done_v[i]) begin nerr++; $display("FAIL job_done[%0d] got=%b want=%b", i, done, done_v[i]); end
      nchk++; if (busy !== busy_v[i]) begin nerr++; $display("FAIL job_busy[%0d] got=%b want=%b", i, busy, busy_v[i]); end
      nchk++; if (ag_base_addr[31:0] !== exp_base[i]) begin nerr++; $display("FAIL job_base0[%0d] got=%h want=%h", i, ag_base_addr[31:0], exp_base[i]); end
      nchk++; if (feat_cnt !== exp_cnt[i]) begin nerr++; $display("FAIL job_cnt[%0d] got=%0d want=%0d", i, feat_cnt, exp_cnt[i]); end
      if (i == 5) begin
        nchk++; if (ag_base_addr[127:96] !== 32'h480) begin nerr++; $display("FAIL job_base3 got=%h want=480", ag_base_addr[127:96]); end
      end
    end
    nchk++; if (n_evt !== 3) begin nerr++; $display("FAIL job_evt_count got=%0d want=3", n_evt); end
    nchk++; if (n_done !== 1) begin nerr++; $display("FAIL job_done_count got=%0d want=1", n_done); end
    @(negedge clk);
    strm_valid = '0; mem_gnt = '0; ag_change_feat = 1'b0;
    #1;
    nchk++; if (feat_cnt !== 16'd3) begin nerr++; $display("FAIL job_cnt_hold got=%0d want=3", feat_cnt); end
  endtask

  // One stream not valid: nothing advances, change_feat is ignored.
  task automatic test_stall;
    launch({4{32'h800}}, 32'h10, 16'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      strm_valid = 4'b1011; mem_gnt = '1; ag_change_feat = 1'b1;
      #1;
      nchk++; if (ag_inc !== 4'h0) begin nerr++; $display("FAIL stall_inc[%0d] got=%h want=0", i, ag_inc); end
      nchk++; if (strm_ready !== 4'h0) begin nerr++; $display("FAIL stall_ready[%0d] got=%h want=0", i, strm_ready); end
      nchk++; if (ag_en !== 4'hF) begin nerr++; $display("FAIL stall_en[%0d] got=%h want=F", i, ag_en); end
      nchk++; if (feat_cnt !== 16'd0) begin nerr++; $display("FAIL stall_cnt[%0d] got=%0d want=0", i, feat_cnt); end
      nchk++; if (evt_feat !== 1'b0) begin nerr++; $display("FAIL stall_evt[%0d] got=%b want=0", i, evt_feat); end
    end
    @(negedge clk);
    strm_valid = '1;
    #1;
    nchk++; if (ag_inc !== 4'hF) begin nerr++; $display("FAIL stall_release_inc got=%h want=F", ag_inc); end
    @(negedge clk);
    strm_valid = '0; mem_gnt = '0; ag_change_feat = 1'b0;
    #1;
    nchk++; if (done !== 1'b1) begin nerr++; $display("FAIL stall_done got=%b want=1", done); end
    nchk++; if (feat_cnt !== 16'd1) begin nerr++; $display("FAIL stall_cnt_end got=%0d want=1", feat_cnt); end
    @(negedge clk);
  endtask

  // n_feat of zero behaves as a single feature.
  task automatic test_zero_feat;
    launch({4{32'h900}}, 32'h10, 16'd0);
    @(negedge clk);
    strm_valid = '1; mem_gnt = '1; ag_change_feat = 1'b1;
    @(negedge clk);
    strm_valid = '0; mem_gnt = '0; ag_change_feat = 1'b0;
    #1;
    nchk++; if (done !== 1'b1) begin nerr++; $display("FAIL zero_done got=%b want=1", done); end
    nchk++; if (feat_cnt !== 16'd1) begin nerr++; $display("FAIL zero_cnt got=%0d want=1", feat_cnt); end
    @(negedge clk);
    #1;
    nchk++; if (busy !== 1'b0) begin nerr++; $display("FAIL zero_idle got=%b want=0", busy); end
    nchk++; if (done !== 1'b0) begin nerr++; $display("FAIL zero_done_once got=%b want=0", done); end
  endtask

  // Negative stride wraps modulo 2^32.
  task automatic test_neg_stride;
    launch({4{32'h40}}, 32'hFFFF_FFC0, 16'd2);
    @(negedge clk);
    strm_valid = '1; mem_gnt = '1; ag_change_feat = 1'b1;
    #1;
    nchk++; if (ag_base_addr[31:0] !== 32'h40) begin nerr++; $display("FAIL neg_base_f0 got=%h want=40", ag_base_addr[31:0]); end
    @(negedge clk);
    #1;
    nchk++; if (ag_base_addr[31:0] !== 32'h0) begin nerr++; $display("FAIL neg_base_f1 got=%h want=0", ag_base_addr[31:0]); end
    nchk++; if (ag_en !== 4'h0) begin nerr++; $display("FAIL neg_fswitch_en got=%h want=0", ag_en); end
    nchk++; if (ag_inc !== 4'h0) begin nerr++; $display("FAIL neg_fswitch_inc got=%h want=0", ag_inc); end
    @(negedge clk);
    @(negedge clk);
    strm_valid = '0; mem_gnt = '0; ag_change_feat = 1'b0;
    #1;
    nchk++; if (done !== 1'b1) begin nerr++; $display("FAIL neg_done got=%b want=1", done); end
    nchk++; if (ag_base_addr[31:0] !== 32'hFFFF_FFC0) begin nerr++; $display("FAIL neg_base_wrap got=%h want=ffffffc0", ag_base_addr[31:0]); end
    @(negedge clk);
  endtask

  // Soft clear while a beat is firing, then a fresh job.
  task automatic test_clear;
    launch({4{32'h500}}, 32'h10, 16'd3);
    @(negedge clk);
    strm_valid = '1; mem_gnt = '1; ag_change_feat = 1'b0;
    #1;
    nchk++; if (ag_inc !== 4'hF) begin nerr++; $display("FAIL clr_pre_inc got=%h want=F", ag_inc); end
    @(negedge clk);
    ag_change_feat = 1'b1; clear = 1'b1;
    #1;
    nchk++; if (ag_inc !== 4'h0) begin nerr++; $display("FAIL clr_drop_inc got=%h want=0", ag_inc); end
    @(negedge clk);
    clear = 1'b0; strm_valid = '0; mem_gnt = '0; ag_change_feat = 1'b0;
    #1;
    nchk++; if (busy !== 1'b0) begin nerr++; $display("FAIL clr_busy got=%b want=0", busy); end
    nchk++; if (done !== 1'b0) begin nerr++; $display("FAIL clr_done got=%b want=0", done); end
    nchk++; if (evt_feat !== 1'b0) begin nerr++; $display("FAIL clr_evt got=%b want=0", evt_feat); end
    nchk++; if (ag_en !== 4'h0) begin nerr++; $display("FAIL clr_en got=%h want=0", ag_en); end
    nchk++; if (ag_base_addr !== '0) begin nerr++; $display("FAIL clr_base got=%h want=0", ag_base_addr); end
    nchk++; if (feat_cnt !== 16'd0) begin nerr++; $display("FAIL clr_cnt got=%0d want=0", feat_cnt); end
    @(negedge clk);
    #1;
    nchk++; if (done !== 1'b0) begin nerr++; $display("FAIL clr_no_done got=%b want=0", done); end
    launch({4{32'h700}}, 32'h10, 16'd1);
    #1;
    nchk++; if (ag_base_addr[31:0] !== 32'h700) begin nerr++; $display("FAIL clr_restart_base got=%h want=700", ag_base_addr[31:0]); end
    @(negedge clk);
    strm_valid = '1; mem_gnt = '1; ag_change_feat = 1'b1;
    @(negedge clk);
    strm_valid = '0; mem_gnt = '0; ag_change_feat = 1'b0;
    #1;
    nchk++; if (done !== 1'b1) begin nerr++; $display("FAIL clr_restart_done got=%b want=1", done); end
    @(negedge clk);
  endtask

  // start while busy and change_feat without full grant are both ignored.
  task automatic test_ignored;
    launch({4{32'h1000}}, 32'h10, 16'd2);
    start = 1'b1;
    @(negedge clk);
    strm_valid = '1; mem_gnt = 4'b1110; ag_change_feat = 1'b1;
    #1;
    nchk++; if (ag_inc !== 4'h0) begin nerr++; $display("FAIL ign_inc got=%h want=0", ag_inc); end
    @(negedge clk);
    start = 1'b0;
    #1;
    nchk++; if (ag_en !== 4'hF) begin nerr++; $display("FAIL ign_still_run got=%h want=F", ag_en); end
    nchk++; if (feat_cnt !== 16'd0) begin nerr++; $display("FAIL ign_cnt got=%0d want=0", feat_cnt); end
    nchk++; if (evt_feat !== 1'b0) begin nerr++; $display("FAIL ign_evt got=%b want=0", evt_feat); end
    nchk++; if (ag_base_addr[31:0] !== 32'h1000) begin nerr++; $display("FAIL ign_base got=%h want=1000", ag_base_addr[31:0]); end
    mem_gnt = '1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    strm_valid = '0; mem_gnt = '0; ag_change_feat = 1'b0;
    #1;
    nchk++; if (done !== 1'b1) begin nerr++; $display("FAIL ign_done got=%b want=1", done); end
    nchk++; if (feat_cnt !== 16'd2) begin nerr++; $display("FAIL ign_cnt_end got=%0d want=2", feat_cnt); end
    nchk++; if (ag_base_addr[31:0] !== 32'h1020) begin nerr++; $display("FAIL ign_base_end got=%h want=1020", ag_base_addr[31:0]); end
    @(negedge clk);
  endtask

  // Asynchronous reset in the middle of RUN.
  task automatic test_async_reset;
    launch({4{32'h600}}, 32'h10, 16'd4);
    @(negedge clk);
    strm_valid = '1; mem_gnt = '1; ag_change_feat = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    nchk++; if (busy !== 1'b0) begin nerr++; $display("FAIL arst_busy got=%b want=0", busy); end
    nchk++; if (ag_inc !== 4'h0) begin nerr++; $display("FAIL arst_inc got=%h want=0", ag_inc); end
    nchk++; if (ag_base_addr !== '0) begin nerr++; $display("FAIL arst_base got=%h want=0", ag_base_addr); end
    nchk++; if (done !== 1'b0) begin nerr++; $display("FAIL arst_done got=%b want=0", done); end
    @(negedge clk);
    rst_n = 1'b1; strm_valid = '0; mem_gnt = '0;
    @(negedge clk);
    #1;
    nchk++; if (done !== 1'b0) begin nerr++; $display("FAIL arst_no_done got=%b want=0", done); end
    nchk++; if (busy !== 1'b0) begin nerr++; $display("FAIL arst_idle got=%b want=0", busy); end
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; start = 1'b0;
    base_addr = '0; feat_stride = '0; n_feat = '0;
    strm_valid = '0; mem_gnt = '0; ag_change_feat = 1'b0;
    test_reset();
    test_basic_job();
    test_stall();
    test_zero_feat();
    test_neg_stride();
    test_clear();
    test_ignored();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
